// File: rtl/alu_cmd_master_pkg.sv
// Shared protocol constants and FSM encoding for the UART ALU command path.
// Used by the host-side initiator and the ALU-side decoder.
package alu_cmd_master_pkg;

  localparam logic [7:0] LOC_A      = 8'h00;
  localparam logic [7:0] LOC_B      = 8'h01;
  localparam logic [7:0] LOC_OP     = 8'h02;
  localparam logic [7:0] CMD_RESULT = 8'hFF;

  // Index of the final (result request) byte in the 7-byte command stream.
  localparam logic [2:0] LAST_IDX = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_TX  = 2'd2,
    ST_WAIT_RES = 2'd3
  } state_e;

endpackage

// File: rtl/alu_cmd_master.sv
// Host-side ALU command initiator: serialises A/B/opcode as location/data
// byte pairs plus a 0xFF result request, then waits for the result byte.
module alu_cmd_master
  import alu_cmd_master_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OPS         = 6,
  parameter int unsigned NB_TMO         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OPS-1:0]  i_ops,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout,
  output logic [1:0]         o_dbg_state
);

  // Handshakes: o_tx_valid is a one-cycle strobe meaning "transmitter takes
  // o_tx_data now"; i_tx_done / i_rx_valid are single-cycle pulses that are
  // only honoured in WAIT_TX / WAIT_RES and dropped in every other state.

  localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OPS-1:0]  ops_q, ops_d;
  logic [NB_TMO-1:0]  cnt_q, cnt_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               timeout_q, timeout_d;

  function automatic logic [NB_DATA-1:0] byte_at(
    input logic [2:0]         idx,
    input logic [NB_DATA-1:0] a,
    input logic [NB_DATA-1:0] b,
    input logic [NB_OPS-1:0]  ops
  );
    case (idx)
      3'd0:    byte_at = NB_DATA'(LOC_A);
      3'd1:    byte_at = a;
      3'd2:    byte_at = NB_DATA'(LOC_B);
      3'd3:    byte_at = b;
      3'd4:    byte_at = NB_DATA'(LOC_OP);
      3'd5:    byte_at = NB_DATA'(ops);
      default: byte_at = NB_DATA'(CMD_RESULT);
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    a_d            = a_q;
    b_d            = b_q;
    ops_d          = ops_q;
    cnt_d          = cnt_q;
    tx_data_d      = tx_data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          a_d       = i_data_a;
          b_d       = i_data_b;
          ops_d     = i_ops;
          idx_d     = 3'd0;
          tx_data_d = byte_at(3'd0, i_data_a, i_data_b, i_ops);
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_WAIT_RES;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = byte_at(idx_q + 3'd1, a_q, b_q, ops_q);
            state_d   = ST_SEND;
          end
        end
      end
      ST_WAIT_RES: begin
        // A result arriving on the terminal count beats the timeout.
        if (i_rx_valid) begin
          result_d       = i_rx_data;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + NB_TMO'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    tx_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      ops_q          <= '0;
      cnt_q          <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      a_q            <= a_d;
      b_q            <= b_d;
      ops_q          <= ops_d;
      cnt_q          <= cnt_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_tx_data      = tx_data_q;
  assign o_tx_valid     = tx_valid_q;
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_timeout      = timeout_q;
  assign o_dbg_state    = state_q;

endmodule

// File: doc/alu_cmd_master.md
# alu_cmd_master

Host-side command initiator for the UART-attached ALU. It latches an operand set (A, B, opcode) and serialises it into the byte protocol the ALU-side interface decodes: location/data pairs, then the 0xFF result request. It then waits for the single result byte returning on the UART receive path. It sits between a test/host controller and a UART transmitter/receiver pair, and drives loopback and board-level ALU regression.

## Interface
- NB_DATA, 8, byte/operand width.
- NB_OPS, 6, opcode width (≤ NB_DATA).
- NB_TMO, 16, timeout counter width.
- TIMEOUT_CYCLES, 16'hFFFF, cycles to wait for the result byte after 0xFF is sent.

- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request a transaction; sampled only in IDLE.
- i_data_a  in  NB_DATA  operand A.
- i_data_b  in  NB_DATA  operand B.
- i_ops  in  NB_OPS  ALU opcode.
- o_busy  out  1  high in every state except IDLE.
- o_tx_data  out  NB_DATA  byte to UART transmitter.
- o_tx_valid  out  1  one-cycle strobe: the transmitter accepts o_tx_data.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- i_rx_data  in  NB_DATA  byte from UART receiver.
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
- o_result  out  NB_DATA  last ALU result; holds until the next valid result.
- o_result_valid  out  1  one-cycle strobe when o_result updates.
- o_timeout  out  1  one-cycle strobe when the result wait expires.

## Operation
- Byte sequence, index 0..6: 0x00, A, 0x01, B, 0x02, {zero-pad, ops}, 0xFF.
- FSM states: IDLE, SEND, WAIT_TX, WAIT_RES.
  - IDLE: on i_start, latch A, B and ops into internal registers, set idx=0, go to SEND. Later changes on the inputs do not affect the transaction.
  - SEND: drive o_tx_valid=1 and o_tx_data=byte[idx] for exactly one cycle, then go to WAIT_TX.
  - WAIT_TX: on i_tx_done, if idx==6, clear the timeout counter and go to WAIT_RES; otherwise increment idx and go to SEND.
  - WAIT_RES: on i_rx_valid, o_result ← i_rx_data, pulse o_result_valid, go to IDLE. Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1, pulse o_timeout and go to IDLE; o_result is unchanged.
- o_tx_data holds its last value outside SEND; only o_tx_valid qualifies it.
- Boundary conditions:
  - i_start while busy: ignored, not queued.
  - i_tx_done outside WAIT_TX: ignored.
  - i_rx_valid outside WAIT_RES: ignored and discarded.
  - i_rx_valid on the same cycle as the timeout terminal count: the result wins and o_timeout stays 0.
  - An operand equal to 0xFF is sent as a data byte with no escaping. The protocol permits this, because a data byte always follows a location byte.
  - Reset mid-transaction: immediate return to IDLE with the sequence aborted; no partial-byte recovery.

## Timing
- Reset values:
  - state=IDLE, idx=0, counter=0.
  - o_busy=0, o_tx_valid=0, o_tx_data=0.
  - o_result=0, o_result_valid=0, o_timeout=0.
- i_start high at edge N: o_busy=1 and o_tx_valid=1 (byte 0x00) in cycle N+1.
- i_tx_done at edge M: the next o_tx_valid is in cycle M+1, giving back-to-back byte issue with a one-cycle gap.
- i_rx_valid at edge R in WAIT_RES: o_result_valid=1 and o_busy=0 in cycle R+1. i_start is accepted from edge R+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package/header, for use with the ALU-side decoder:
  - location constants LOC_A=0x00, LOC_B=0x01, LOC_OP=0x02;
  - CMD_RESULT=0xFF;
  - state encodings.
- Single module. The byte mux is an index-selected case; no sub-module is needed.

## Test plan
- Reset, then i_start with A=0x05, B=0x03, ops=0x20 and i_tx_done two cycles after each strobe:
  - o_tx_data strobes 00,05,01,03,02,20,FF in order;
  - i_rx_valid with 0x08 → o_result=0x08, o_result_valid one cycle, o_busy=0.
- Operand A=0xFF, B=0x00: the stream is 00,FF,01,00,02,xx,FF, exactly 7 strobes.
- Timeout, with TIMEOUT_CYCLES=16 and no i_rx_valid after FF: o_timeout pulses, state returns to IDLE, o_result keeps its prior value.
- Ignored events:
  - i_start pulsed during WAIT_TX → no second transaction;
  - i_rx_valid during SEND → o_result unchanged.
- i_reset asserted after the third byte: the next cycle has all outputs at reset values; a new i_start restarts from byte 0x00.
- i_rx_valid on the timeout terminal cycle: o_result_valid=1, o_timeout=0.
